// File: rtl/uart_ser.sv
// Transmit-side UART serializer: takes words from a ready/valid stream and shifts
// them out on uart_txd as start, DW data bits LSB first, optional parity, SW stop bits.
module uart_ser #(
  parameter int    DW = 8,
  parameter string PT = "NONE",
  parameter int    SW = 1,
  parameter int    BN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          str_tvalid,
  input  logic [DW-1:0] str_tdata,
  output logic          str_tready,
  output logic          busy,
  output logic          uart_txd
);

  // Any parity string other than EVEN/ODD disables the parity bit.
  localparam bit PAR_EN  = (PT == "EVEN") || (PT == "ODD");
  localparam bit PAR_ODD = (PT == "ODD");

  localparam int NC_MAX = (DW > SW) ? DW : SW;
  localparam int BW     = (BN > 1) ? $clog2(BN) : 1;
  localparam int NW     = (NC_MAX > 1) ? $clog2(NC_MAX) : 1;

  localparam logic [BW-1:0] BC_LAST   = BW'(BN - 1);
  localparam logic [NW-1:0] DATA_LAST = NW'(DW - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(SW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_bc;
  logic [NW-1:0] r_nc;
  logic [DW-1:0] r_shift;
  logic          r_par;
  logic          r_txd;
  logic          r_busy;

  state_t        w_state_next;
  logic [BW-1:0] w_bc_next;
  logic [NW-1:0] w_nc_next;
  logic [DW-1:0] w_shift_next;
  logic          w_par_next;
  logic          w_txd_next;
  logic          w_busy_next;

  logic w_bit_end;
  logic w_last_stop;
  logic w_xfer;

  assign w_bit_end   = (r_bc == BC_LAST);
  assign w_last_stop = (r_state == S_STOP) && (r_nc == STOP_LAST) && w_bit_end;
  assign str_tready  = (r_state == S_IDLE) || w_last_stop;
  assign w_xfer      = str_tvalid && str_tready;

  assign busy     = r_busy;
  assign uart_txd = r_txd;

  always_comb begin
    w_state_next = r_state;
    w_bc_next    = r_bc;
    w_nc_next    = r_nc;
    w_shift_next = r_shift;
    w_par_next   = r_par;

    if (r_state != S_IDLE) begin
      w_bc_next = w_bit_end ? '0 : r_bc + BW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_nc_next    = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_nc == DATA_LAST) begin
            w_state_next = PAR_EN ? S_PARITY : S_STOP;
            w_nc_next    = '0;
          end else begin
            w_nc_next = r_nc + NW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_next = S_STOP;
          w_nc_next    = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_nc == STOP_LAST) begin
            w_state_next = S_IDLE;
            w_nc_next    = '0;
          end else begin
            w_nc_next = r_nc + NW'(1);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_bc_next    = '0;
        w_nc_next    = '0;
      end
    endcase

    // A transfer (from IDLE or the last stop cycle) overrides and starts a new frame.
    if (w_xfer) begin
      w_state_next = S_START;
      w_bc_next    = '0;
      w_nc_next    = '0;
      w_shift_next = str_tdata;
      w_par_next   = (^str_tdata) ^ PAR_ODD;
    end
  end

  // The line level is registered from the next state so the start bit appears
  // in the cycle right after the transfer edge.
  always_comb begin
    w_txd_next  = 1'b1;
    w_busy_next = (w_state_next != S_IDLE);
    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = w_shift_next[0];
      S_PARITY: w_txd_next = w_par_next;
      default:  w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bc    <= '0;
      r_nc    <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bc    <= w_bc_next;
      r_nc    <= w_nc_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_txd   <= w_txd_next;
      r_busy  <= w_busy_next;
    end
  end

endmodule

// File: doc/uart_ser.md
Name: uart_ser

Overview:
- Transmit-side UART serializer. Accepts DW-bit words on an AXI-stream-style slave interface and drives them onto the UART TXD line.
- Frame format: start bit, DW data bits LSB first, optional parity bit, SW stop bits.
- Frame format and bit period match the UART receive path: same DW/PT/SW/BN parameter set, so a looped-back TXD decodes cleanly.
- Sits between the host-side stream fabric and the TXD pin.

Parameters:
DW, 8, data width in bits, >=1
PT, "NONE", parity type: "EVEN", "ODD" or "NONE"
SW, 1, number of stop bits, >=1
BN, 2, clock periods per UART bit, >=1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
str_tvalid  input  1  stream word valid
str_tdata  input  DW  stream word
str_tready  output  1  serializer can accept a word this cycle
busy  output  1  a frame is in progress on uart_txd
uart_txd  output  1  UART serial output, idle high

Behaviour:
- Clock and reset:
  - One clock (clk).
  - rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values (registered outputs, effective the cycle after rst is sampled high):
  - uart_txd=1, busy=0, str_tready=1, state=IDLE, all counters 0.
- Handshake:
  - A transfer occurs on a rising edge where str_tvalid && str_tready.
  - str_tdata is captured into a shift register at the transfer edge. Later changes on str_tdata have no effect.
  - The parity bit is computed from the captured word at the transfer edge.
  - str_tready is combinational from state/counters: high in IDLE, and also in the final clk cycle of the final stop bit. It is low otherwise.
  - str_tvalid may be held high without a transfer; no effect until str_tready is high.
- Counters:
  - Baud counter bc counts 0..BN-1. Each UART bit lasts exactly BN clk cycles.
  - Bit counter nc indexes data bits (0..DW-1) and stop bits (0..SW-1).
  - Widths are clog2 of the respective maxima, minimum 1 bit.
- State machine (uart_txd is registered and reflects the current state):
  - IDLE: uart_txd=1, busy=0. On transfer -> START, bc=0.
  - START: uart_txd=0 for BN cycles -> DATA, nc=0.
  - DATA: uart_txd=shift[0]; shift right at each bit end. After bit DW-1 -> PARITY if PT!="NONE", else STOP.
  - PARITY: uart_txd=p for BN cycles -> STOP, nc=0.
    - EVEN: p = XOR of data bits.
    - ODD: p = ~XOR of data bits.
  - STOP: uart_txd=1 for SW*BN cycles. In the final cycle (nc==SW-1, bc==BN-1):
    - if a transfer occurs -> START (back-to-back, no idle gap);
    - otherwise -> IDLE.
- Latency and frame length:
  - First start-bit cycle on uart_txd is the cycle immediately after the transfer edge.
  - Frame length F = (1 + DW + (PT!="NONE") + SW) * BN cycles.
  - busy is high for all F cycles of the frame.
- Boundary conditions:
  - BN=1: every bit lasts exactly one cycle; bc stays at 0.
  - Continuous str_tvalid: frames are emitted back-to-back with the period exactly F.
  - rst asserted mid-frame: the frame is aborted, uart_txd=1 on the next cycle, and the captured word is discarded (not resent).
  - rst and str_tvalid high in the same cycle: reset wins; no transfer occurs.
  - An invalid PT string is treated as "NONE".

Test Plan:
1. Single word, no parity: DW=8, PT="NONE", SW=1, BN=2; send 0xA5.
   -> uart_txd shows 0,1,0,1,0,0,1,0,1,1, each held 2 cycles; frame is 20 cycles; busy high for 20 cycles; str_tready low from the cycle after the transfer until cycle 20 of the frame.
2. Parity types: PT="EVEN", send 0x07 -> parity bit 1, frame 22 cycles. PT="ODD", send 0x07 -> parity bit 0. PT="ODD", send 0x00 -> parity bit 1.
3. Back-to-back: str_tvalid held high with 0x55 then 0x0F, BN=2.
   -> second start bit follows the stop bit with no idle cycle; total 40 cycles; exactly two transfers.
4. Multi-stop with BN=1: SW=2, BN=1, PT="NONE", send 0xFF.
   -> 0, then eight 1s, then two stop 1s; frame 11 cycles; str_tready high only in cycle 11.
5. Reset mid-frame: assert rst for 1 cycle during data bit 3 of 0x00.
   -> uart_txd=1, busy=0, str_tready=1 the next cycle; no residual bits; a new word sent afterwards produces a clean frame.
6. Data stability: change str_tdata every cycle after a transfer of 0x3C.
   -> the serialized bits still match 0x3C; holding str_tvalid low leaves uart_txd at 1 indefinitely.
